// File: rtl/cla_group_serial_sub_if.sv
// Operand/result handshake bundle for cla_group_serial_sub.
// master = operand producer / result consumer side, slave = the subtractor.
interface cla_group_serial_sub_if #(
   parameter int unsigned ADDER_SIZE = 16
);
   logic                  IN_VALID;
   logic                  IN_READY;
   logic [ADDER_SIZE:1]   A;
   logic [ADDER_SIZE:1]   B;
   logic                  BIN;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [ADDER_SIZE:1]   DIFF;
   logic                  BOUT;
   logic                  OVF;

   modport master (
      output IN_VALID, A, B, BIN, OUT_READY,
      input  IN_READY, OUT_VALID, DIFF, BOUT, OVF
   );

   modport slave (
      input  IN_VALID, A, B, BIN, OUT_READY,
      output IN_READY, OUT_VALID, DIFF, BOUT, OVF
   );
endinterface

// File: rtl/cla_group_serial_sub.sv
// Group-serial carry-lookahead subtractor: DIFF = A - B - BIN, one group per clock, LSB first.
// Optional APPROX_LSB_GROUP_EN: group 0 becomes a lower-part-OR approximation, BIN ignored.
module cla_group_serial_sub #(
   parameter int unsigned ADDER_SIZE = 16,
   parameter int unsigned GROUP_SIZE = 4
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   cla_group_serial_sub_if.slave  bus
);
   localparam int unsigned NGROUPS = ADDER_SIZE / GROUP_SIZE;
   localparam int unsigned IDX_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                   state_q;
   logic [ADDER_SIZE:1]      a_q;
   logic [ADDER_SIZE:1]      nb_q;
   logic [ADDER_SIZE:1]      diff_q;
   logic                     a_msb_q;
   logic                     nb_msb_q;
   logic                     carry_q;
   logic                     bout_q;
   logic                     ovf_q;
   logic                     out_valid_q;
   logic [IDX_W-1:0]         idx_q;

   logic [GROUP_SIZE-1:0]    grp_a;
   logic [GROUP_SIZE-1:0]    grp_nb;
   logic [GROUP_SIZE-1:0]    grp_g;
   logic [GROUP_SIZE-1:0]    grp_p;
   logic [GROUP_SIZE:0]      grp_c;
   logic [GROUP_SIZE-1:0]    grp_diff_d;
   logic                     grp_cout_d;
   logic [ADDER_SIZE+GROUP_SIZE:1] diff_cat;
   logic [ADDER_SIZE:1]      diff_d;
   logic                     ovf_d;
   logic                     last_grp;

   // Lookahead over the current low group; each carry is expanded into its
   // flat generate/propagate sum-of-products form rather than rippled.
   always_comb begin
      grp_a  = a_q[GROUP_SIZE:1];
      grp_nb = nb_q[GROUP_SIZE:1];
      grp_g  = grp_a & grp_nb;
      grp_p  = grp_a ^ grp_nb;
      grp_c  = '0;
      grp_c[0] = carry_q;
      for (int i = 1; i <= int'(GROUP_SIZE); i++) begin
         logic c_acc;
         logic p_acc;
         c_acc = 1'b0;
         p_acc = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            c_acc = c_acc | (p_acc & grp_g[j]);
            p_acc = p_acc & grp_p[j];
         end
         grp_c[i] = c_acc | (p_acc & carry_q);
      end
      grp_diff_d = grp_p ^ grp_c[GROUP_SIZE-1:0];
      grp_cout_d = grp_c[GROUP_SIZE];
`ifdef APPROX_LSB_GROUP_EN
      if (idx_q == '0) begin
         grp_diff_d = grp_a | grp_nb;
         grp_cout_d = grp_g[GROUP_SIZE-1];
      end
`endif
   end

   // Result fills from the top: after NGROUPS shifts group 0 lands at the LSB.
   assign diff_cat = {grp_diff_d, diff_q};
   assign diff_d   = diff_cat[ADDER_SIZE+GROUP_SIZE:GROUP_SIZE+1];
   assign ovf_d    = (a_msb_q != ~nb_msb_q) & (grp_diff_d[GROUP_SIZE-1] != a_msb_q);
   assign last_grp = (idx_q == IDX_W'(NGROUPS - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         a_q         <= '0;
         nb_q        <= '0;
         diff_q      <= '0;
         a_msb_q     <= 1'b0;
         nb_msb_q    <= 1'b0;
         carry_q     <= 1'b0;
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.IN_VALID) begin
                  a_q      <= bus.A;
                  nb_q     <= ~bus.B;
                  a_msb_q  <= bus.A[ADDER_SIZE];
                  nb_msb_q <= ~bus.B[ADDER_SIZE];
                  carry_q  <= ~bus.BIN;
                  idx_q    <= '0;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> GROUP_SIZE;
               nb_q    <= nb_q >> GROUP_SIZE;
               diff_q  <= diff_d;
               carry_q <= grp_cout_d;
               idx_q   <= idx_q + IDX_W'(1);
               if (last_grp) begin
                  bout_q      <= ~grp_cout_d;
                  ovf_q       <= ovf_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.OUT_READY) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.IN_READY  = (state_q == IDLE);
   assign bus.OUT_VALID = out_valid_q;
   assign bus.DIFF      = diff_q;
   assign bus.BOUT      = bout_q;
   assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_cla_group_serial_sub.sv
// Directed-vector bench for cla_group_serial_sub (default 16-bit, 4-bit groups).
// Expected values are hand-computed; APPROX_LSB_GROUP_EN selects the approximate vectors.
module tb_cla_group_serial_sub;
   localparam int unsigned N = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cla_group_serial_sub_if #(.ADDER_SIZE(N)) bus ();

   cla_group_serial_sub #(.ADDER_SIZE(N), .GROUP_SIZE(4)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full transaction: accept, scramble inputs, wait for result, drain.
   task automatic run_op(input string tag, input logic [N:1] a, input logic [N:1] b,
                         input logic bin, input logic [N:1] exp_diff,
                         input logic exp_bout, input logic exp_ovf);
      int lat;
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(bus.IN_READY), 32'd1);
      bus.IN_VALID = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.BIN      = bin;
      @(posedge clk);
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      bus.A        = ~a;
      bus.B        = a ^ b;
      bus.BIN      = ~bin;
      check({tag, " in_ready busy"}, 32'(bus.IN_READY), 32'd0);
      lat = 0;
      while (!bus.OUT_VALID && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " diff"}, 32'(bus.DIFF), 32'(exp_diff));
      check({tag, " bout"}, 32'(bus.BOUT), 32'(exp_bout));
      check({tag, " ovf"}, 32'(bus.OVF), 32'(exp_ovf));
      bus.OUT_READY = 1'b1;
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      check({tag, " out_valid drop"}, 32'(bus.OUT_VALID), 32'd0);
      check({tag, " in_ready back"}, 32'(bus.IN_READY), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [N:1] bp_diff;
      int         stale;
      bus.IN_VALID  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.BIN       = 1'b0;
      bus.OUT_READY = 1'b0;

      repeat (2) @(negedge clk);
      check("reset diff", 32'(bus.DIFF), 32'd0);
      check("reset bout", 32'(bus.BOUT), 32'd0);
      check("reset ovf", 32'(bus.OVF), 32'd0);
      check("reset out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("reset in_ready", 32'(bus.IN_READY), 32'd1);
      rst_n = 1'b1;

`ifdef APPROX_LSB_GROUP_EN
      run_op("approx 5-3", 16'h0005, 16'h0003, 1'b0, 16'hFFFD, 1'b1, 1'b0);
      run_op("approx bin ignored", 16'h0005, 16'h0003, 1'b1, 16'hFFFD, 1'b1, 1'b0);
      bp_diff = 16'h0FFF;
`else
      run_op("exact", 16'h01E0, 16'h000F, 1'b0, 16'h01D1, 1'b0, 1'b0);
      run_op("borrow in", 16'h01E0, 16'h000F, 1'b1, 16'h01D0, 1'b0, 1'b0);
      run_op("negative", 16'h000F, 16'h01E0, 1'b0, 16'hFE2F, 1'b1, 1'b0);
      run_op("overflow", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
      run_op("neg overflow", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      run_op("equal bin", 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      run_op("exact 5-3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
      bp_diff = 16'h1000;
`endif

      // Backpressure: result held while IN_VALID and operands toggle.
      @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.A        = 16'h1234;
      bus.B        = 16'h0234;
      bus.BIN      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", 32'(bus.OUT_VALID), 32'd1);
         check("bp in_ready", 32'(bus.IN_READY), 32'd0);
         check("bp diff", 32'(bus.DIFF), 32'(bp_diff));
         check("bp bout", 32'(bus.BOUT), 32'd0);
         check("bp ovf", 32'(bus.OVF), 32'd0);
         bus.IN_VALID = ~bus.IN_VALID;
         bus.A        = N'($urandom);
         bus.B        = N'($urandom);
         @(negedge clk);
      end
      bus.IN_VALID  = 1'b0;
      bus.OUT_READY = 1'b1;
      @(negedge clk);
      bus.OUT_READY = 1'b0;
      check("bp release in_ready", 32'(bus.IN_READY), 32'd1);
      check("bp release out_valid", 32'(bus.OUT_VALID), 32'd0);

      // Reset two cycles into RUN aborts the operation.
      @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.A        = 16'h01E0;
      bus.B        = 16'h000F;
      bus.BIN      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.IN_VALID = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst diff", 32'(bus.DIFF), 32'd0);
      check("rst out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst in_ready", 32'(bus.IN_READY), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.OUT_VALID) stale++;
      end
      check("rst no stale result", 32'(stale), 32'd0);
      check("rst in_ready after", 32'(bus.IN_READY), 32'd1);

`ifdef APPROX_LSB_GROUP_EN
      run_op("after reset", 16'h0005, 16'h0003, 1'b0, 16'hFFFD, 1'b1, 1'b0);
`else
      run_op("after reset", 16'h01E0, 16'h000F, 1'b0, 16'h01D1, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
